imem_load_ctrl: RTL

//  Host-side IMEM program loader/sequencer. Drives the system's pmem_we/addr/wd/rd port.

---
 rtl/imem_load_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Host-side IMEM loader: streams a program image into IMEM while holding the core in reset,
// reads it back to compare a wrap-around checksum, and releases the core only on a clean image.
module imem_load_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wd,
  input  logic [DATA_W-1:0] pmem_rd,
  output logic              cpu_rst_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {IDLE, WRITE, WLAST, VERIFY, CHECK, DONE, ERR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, idx;
  logic [DATA_W-1:0] wsum, rsum;
  logic              hs, count_ok, active, last_idx, start_ok;

  assign count_ok   = (word_count != '0) && (word_count <= (ADDR_W+1)'(DEPTH));
  assign active     = (state == WRITE) || (state == WLAST) || (state == VERIFY) || (state == CHECK);
  // abort drops ready in the same cycle so a colliding word is never written
  assign host_ready = (state == WRITE) && !abort;
  assign hs         = host_ready && host_valid;
  assign last_idx   = (idx == cnt - 1'b1);
  assign start_ok   = ((state == IDLE) || (state == ERR)) && start && count_ok;
  assign busy       = (state != IDLE) && (state != ERR);
  assign done       = (state == DONE);

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR: if (start) state_nxt = count_ok ? WRITE : ERR;
      WRITE:     if (abort) state_nxt = ERR;
                 else if (hs && last_idx) state_nxt = WLAST;
      WLAST:     state_nxt = abort ? ERR : VERIFY;
      VERIFY:    if (abort) state_nxt = ERR;
                 else if (last_idx) state_nxt = CHECK;
      CHECK:     if (abort) state_nxt = ERR;
                 else state_nxt = (rsum == wsum) ? DONE : ERR;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      pmem_we      <= 1'b0;
      pmem_addr    <= '0;
      pmem_wd      <= '0;
      cpu_rst_hold <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      pmem_we <= 1'b0;
      case (state)
        IDLE, ERR: if (start) begin
          if (count_ok) begin
            error        <= 1'b0;
            err_code     <= 2'd0;
            cpu_rst_hold <= 1'b1;
          end else begin
            error    <= 1'b1;
            err_code <= 2'd1;
          end
        end
        WRITE: if (hs) begin
          pmem_we   <= 1'b1;
          pmem_addr <= idx[ADDR_W-1:0];
          pmem_wd   <= host_data;
        end
        WLAST:  pmem_addr <= '0;
        // address runs one ahead so pmem_rd presents word idx during its VERIFY cycle
        VERIFY: pmem_addr <= idx[ADDR_W-1:0] + 1'b1;
        CHECK: if (!abort && (rsum != wsum)) begin
          error    <= 1'b1;
          err_code <= 2'd2;
        end
        DONE:    cpu_rst_hold <= 1'b0;
        default: ;
      endcase
      if (active && abort) begin
        error    <= 1'b1;
        err_code <= 2'd3;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (start_ok) begin
      cnt  <= word_count;
      idx  <= '0;
      wsum <= '0;
      rsum <= '0;
    end else begin
      case (state)
        WRITE: if (hs) begin
          idx  <= idx + 1'b1;
          wsum <= wsum + host_data;
        end
        WLAST:  idx <= '0;
        VERIFY: begin
          idx  <= idx + 1'b1;
          rsum <= rsum + pmem_rd;
        end
        default: ;
      endcase
    end
  end

endmodule
